hack_memory: RTL and testbench
==============================

Name: hack_memory

Overview:
- Data-memory responder on the Hack CPU's M-interface (addressM/outM/writeM in, inM out).
- Address map: RAM 0x0000–0x3FFF, screen framebuffer 0x4000–0x5FFF, keyboard register 0x6000, control/status 0x6001.
- Provides a registered read port so the video scanout can read the framebuffer.
- Turns raw key press/release events into the Hack KBD semantics: the current key is held while pressed, 0 when none.

Parameters:
KEY_HOLD_CYCLES, 2500000, cycles a key stays latched without a repeat/release event (auto-clear timeout)
KEY_HOLD_W, 22, width of the hold counter; must satisfy 2^KEY_HOLD_W > KEY_HOLD_CYCLES

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
address  input  15  CPU addressM (already registered in the CPU)
data_in  input  16  CPU outM
write_en  input  1  CPU writeM
data_out  output  16  CPU inM, combinational from address
vid_addr  input  13  framebuffer word address for scanout
vid_rd  input  1  scanout read request
vid_data  output  16  scanout read data
vid_valid  output  1  one-cycle strobe; vid_data is valid
key_strobe  input  1  one-cycle key event
key_code  input  8  Hack key code for the event
key_release  input  1  qualifies key_strobe: 1 = release, 0 = press

Behaviour:
- Reset: synchronous, active-high; clock clk.
  - Clears vid_data=0, vid_valid=0, kbd=0, hold counter=0, clear engine idle.
  - RAM and screen contents are NOT cleared.
- Decode: address[14]=0 selects RAM[address[13:0]]. 0x4000–0x5FFF selects screen[address[12:0]]. 0x6000 selects KBD. 0x6001 selects CTRL. 0x6002–0x7FFF are unmapped.
- CPU read: data_out is combinational from the current address and array contents, with zero added latency.
  - Unmapped addresses read 0x0000.
  - KBD reads {8'h00, kbd}.
- CPU write: when write_en=1, the selected RAM/screen word takes data_in at the next posedge.
  - A read of the same address in the write cycle returns the old value; the following cycle returns the new value.
  - Writes to KBD and to unmapped addresses are ignored.
- Video port: vid_rd=1 in cycle N gives vid_data=screen[vid_addr] and vid_valid=1 in cycle N+1.
  - vid_valid=0 whenever no read was issued in the previous cycle; vid_data holds its last value.
  - Back-to-back reads are allowed every cycle.
  - A video read of a word the CPU writes in the same cycle returns the old data.
- Keyboard: priority order, highest first:
  - Press (key_strobe=1, key_release=0, key_code!=0): kbd<=key_code and hold counter<=KEY_HOLD_CYCLES. A new press overwrites an older key.
  - Press with key_code=0: ignored.
  - Release (key_strobe=1, key_release=1): if key_code==kbd, kbd<=0 and counter<=0. A release of a different key is ignored.
  - Otherwise, if kbd!=0: the counter decrements; when the counter is 1 the next edge sets kbd<=0 and counter<=0.
- Reset during any keyboard or clear activity returns the block to the reset state on the next edge.

Optional Feature:
- Macro SCREEN_CLEAR_EN.
- Defined: CTRL at 0x6001 reads {15'b0, busy}.
  - A CPU write to 0x6001 with data_in[0]=1 while idle sets busy=1 and ptr=0.
  - Each subsequent cycle writes 0x0000 to screen[ptr] and increments ptr; after ptr=8191 is written, busy=0 (8192 busy cycles).
  - A CPU screen write in the same cycle takes priority, and the engine stalls one cycle; a video read does not stall it.
  - A start write while busy is ignored.
  - Reset aborts the clear, leaving a partially cleared screen with busy=0.
- Undefined: 0x6001 is unmapped (reads 0, writes ignored), and no clear logic is synthesised.

Test Plan:
- Write 0x1234 to 0x0005, then read 0x0005 -> data_out=0x1234 in the cycle after the write; in the write cycle data_out shows the prior contents. Read 0x6002 -> 0x0000.
- Write 0xBEEF to 0x4010, then vid_rd=1 with vid_addr=0x0010 -> next cycle vid_valid=1, vid_data=0xBEEF; the cycle after that, with no request, vid_valid=0.
- Press code 0x41 -> data_out at 0x6000 reads 0x0041. Press 0x42 -> 0x0042. Release 0x41 -> stays 0x0042. Release 0x42 -> 0x0000.
- With KEY_HOLD_CYCLES=10: press 0x20 and send no further events -> KBD reads 0x0020 for exactly 10 cycles, then 0x0000. Reset asserted mid-hold -> 0x0000 the next cycle.
- SCREEN_CLEAR_EN: fill 0x4000/0x5FFF with 0xFFFF, write 1 to 0x6001 -> 0x6001 reads 1 for 8192 cycles (+1 per stalled CPU screen write), then 0; both words read 0x0000 afterwards.
- SCREEN_CLEAR_EN: reset after 100 clear cycles -> busy=0 immediately; words ≥ ptr keep 0xFFFF.

Source files
------------

// File: rtl/hack_memory.sv
// hack_memory -- data-memory responder on the Hack CPU M-interface.
//
// Address map (15-bit word address):
//   0x0000-0x3FFF  RAM (16K words)
//   0x4000-0x5FFF  screen framebuffer (8K words)
//   0x6000         KBD: {8'h00, current key}, 0 when no key is held
//   0x6001         CTRL: {15'b0, busy} when SCREEN_CLEAR_EN is defined,
//                  otherwise unmapped
//   0x6002-0x7FFF  unmapped (read 0, writes ignored)
//
// Optional feature macro: SCREEN_CLEAR_EN. When it is defined, writing
// data_in[0]=1 to 0x6001 starts a background engine that zeroes the whole
// framebuffer, one word per cycle.
//
// Ports:
//   clk, reset          clock; synchronous active-high reset
//   address, data_in,   CPU addressM / outM / writeM
//   write_en
//   data_out            CPU inM, combinational from address
//   vid_addr, vid_rd    scanout read request (framebuffer word address)
//   vid_data, vid_valid scanout read data, valid one cycle after vid_rd
//   key_strobe,         one-cycle key event with its Hack key code;
//   key_code,           key_release=1 marks a release, 0 a press
//   key_release
//
// RAM and screen contents are not affected by reset.
module hack_memory #(
    parameter int KEY_HOLD_CYCLES = 2500000,
    parameter int KEY_HOLD_W      = 22
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [14:0] address,
    input  logic [15:0] data_in,
    input  logic        write_en,
    output logic [15:0] data_out,
    input  logic [12:0] vid_addr,
    input  logic        vid_rd,
    output logic [15:0] vid_data,
    output logic        vid_valid,
    input  logic        key_strobe,
    input  logic [7:0]  key_code,
    input  logic        key_release
);

    logic [15:0] ram    [0:16383];
    logic [15:0] screen [0:8191];

    logic [7:0]            kbd;
    logic [KEY_HOLD_W-1:0] hold_cnt;

    // Address decode
    logic sel_ram, sel_scr, sel_kbd, sel_ctrl;
    assign sel_ram  = ~address[14];
    assign sel_scr  = (address[14:13] == 2'b10);
    assign sel_kbd  = (address == 15'h6000);
    assign sel_ctrl = (address == 15'h6001);

    logic cpu_ram_wr, cpu_scr_wr;
    assign cpu_ram_wr = write_en & sel_ram;
    assign cpu_scr_wr = write_en & sel_scr;

`ifdef SCREEN_CLEAR_EN
    logic        clr_busy;
    logic [12:0] clr_ptr;

    // The CPU owns the single screen write port when it writes the screen;
    // the engine simply retries the same pointer next cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            clr_busy <= 1'b0;
            clr_ptr  <= '0;
        end else if (!clr_busy) begin
            if (write_en && sel_ctrl && data_in[0]) begin
                clr_busy <= 1'b1;
                clr_ptr  <= '0;
            end
        end else if (!cpu_scr_wr) begin
            clr_ptr <= clr_ptr + 13'd1;
            if (clr_ptr == 13'h1FFF)
                clr_busy <= 1'b0;
        end
    end
`endif

    // CPU read: zero-latency, straight off the arrays
    always_comb begin
        data_out = 16'h0000;
        if (sel_ram)
            data_out = ram[address[13:0]];
        else if (sel_scr)
            data_out = screen[address[12:0]];
        else if (sel_kbd)
            data_out = {8'h00, kbd};
`ifdef SCREEN_CLEAR_EN
        else if (sel_ctrl)
            data_out = {15'b0, clr_busy};
`endif
    end

    always_ff @(posedge clk) begin
        if (cpu_ram_wr)
            ram[address[13:0]] <= data_in;
    end

    always_ff @(posedge clk) begin
        if (cpu_scr_wr)
            screen[address[12:0]] <= data_in;
`ifdef SCREEN_CLEAR_EN
        // Gated by reset so an aborted clear stops exactly where it was.
        else if (clr_busy && !reset)
            screen[clr_ptr] <= 16'h0000;
`endif
    end

    // Scanout port: reads the pre-edge array, so a same-cycle CPU write
    // to the same word is not visible here.
    always_ff @(posedge clk) begin
        if (reset) begin
            vid_valid <= 1'b0;
            vid_data  <= 16'h0000;
        end else begin
            vid_valid <= vid_rd;
            if (vid_rd)
                vid_data <= screen[vid_addr];
        end
    end

    // Keyboard latch. Ignored events (press of code 0, release of a key
    // that is not current) do not disturb the hold timer, which keeps
    // counting down as on an idle cycle.
    logic key_press, key_rel_hit;
    assign key_press   = key_strobe & ~key_release & (key_code != 8'h00);
    assign key_rel_hit = key_strobe &  key_release & (key_code == kbd);

    always_ff @(posedge clk) begin
        if (reset) begin
            kbd      <= 8'h00;
            hold_cnt <= '0;
        end else if (key_press) begin
            kbd      <= key_code;
            hold_cnt <= KEY_HOLD_W'(KEY_HOLD_CYCLES);
        end else if (key_rel_hit) begin
            kbd      <= 8'h00;
            hold_cnt <= '0;
        end else if (kbd != 8'h00) begin
            if (hold_cnt <= KEY_HOLD_W'(1)) begin
                kbd      <= 8'h00;
                hold_cnt <= '0;
            end else begin
                hold_cnt <= hold_cnt - KEY_HOLD_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_hack_memory.sv
// Testbench for hack_memory (KEY_HOLD_CYCLES=10). Honours SCREEN_CLEAR_EN
// the same way the design does.
module tb_hack_memory;
    localparam int H = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [14:0] address = '0;
    logic [15:0] data_in = '0;
    logic        write_en = 1'b0;
    logic [15:0] data_out;
    logic [12:0] vid_addr = '0;
    logic        vid_rd = 1'b0;
    logic [15:0] vid_data;
    logic        vid_valid;
    logic        key_strobe = 1'b0;
    logic [7:0]  key_code = '0;
    logic        key_release = 1'b0;

    hack_memory #(.KEY_HOLD_CYCLES(H), .KEY_HOLD_W(4)) dut (
        .clk(clk), .reset(reset), .address(address), .data_in(data_in),
        .write_en(write_en), .data_out(data_out), .vid_addr(vid_addr),
        .vid_rd(vid_rd), .vid_data(vid_data), .vid_valid(vid_valid),
        .key_strobe(key_strobe), .key_code(key_code), .key_release(key_release)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;
    int cyc = 0;

    // Reference model: plain arrays plus a key/expiry-time pair
    logic [15:0] m_ram [0:16383];
    logic [15:0] m_scr [0:8191];
    bit          m_ram_ok [0:16383];
    bit          m_scr_ok [0:8191];
    logic [7:0]  m_key = 8'h00;
    int          m_expire = 0;
    logic        m_vvalid = 1'b0;
    logic [15:0] m_vdata = 16'h0;
    bit          m_vknown = 1'b1;

    logic [15:0] s_dout, s_vd;
    logic        s_vv;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] model_read(input logic [14:0] a, output bit known);
        known = 1'b1;
        if (a < 15'h4000) begin
            known = m_ram_ok[a[13:0]];
            return m_ram[a[13:0]];
        end else if (a < 15'h6000) begin
            known = m_scr_ok[a[12:0]];
            return m_scr[a[12:0]];
        end else if (a == 15'h6000) begin
            return {8'h00, m_key};
        end
        return 16'h0000;
    endfunction

    task automatic model_edge();
        if (reset) begin
            m_key = 8'h00; m_vvalid = 1'b0; m_vdata = 16'h0; m_vknown = 1'b1;
        end else begin
            m_vvalid = vid_rd;
            if (vid_rd) begin
                m_vdata  = m_scr[vid_addr];
                m_vknown = m_scr_ok[vid_addr];
            end
            if (key_strobe && !key_release && key_code != 8'h00) begin
                m_key = key_code;
                m_expire = cyc + 1 + H;
            end else if (key_strobe && key_release && key_code == m_key)
                m_key = 8'h00;
            else if (m_key != 8'h00 && cyc + 1 >= m_expire)
                m_key = 8'h00;
            if (write_en) begin
                if (address < 15'h4000) begin
                    m_ram[address[13:0]] = data_in; m_ram_ok[address[13:0]] = 1'b1;
                end else if (address < 15'h6000) begin
                    m_scr[address[12:0]] = data_in; m_scr_ok[address[12:0]] = 1'b1;
                end
            end
        end
        cyc++;
    endtask

    // One clock cycle: drive, sample outputs mid-cycle, advance model at the edge
    task automatic step(input logic [14:0] a, input logic [15:0] d, input logic we,
                        input logic vr, input logic [12:0] va,
                        input logic ks, input logic [7:0] kc, input logic kr);
        address = a; data_in = d; write_en = we; vid_rd = vr; vid_addr = va;
        key_strobe = ks; key_code = kc; key_release = kr;
        @(negedge clk);
        s_dout = data_out; s_vv = vid_valid; s_vd = vid_data;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic rd(input logic [14:0] a);
        step(a, 16'h0, 1'b0, 1'b0, 13'h0, 1'b0, 8'h0, 1'b0);
    endtask
    task automatic wr(input logic [14:0] a, input logic [15:0] d);
        step(a, d, 1'b1, 1'b0, 13'h0, 1'b0, 8'h0, 1'b0);
    endtask
    task automatic key(input logic [7:0] c, input logic rel);
        step(15'h6000, 16'h0, 1'b0, 1'b0, 13'h0, 1'b1, c, rel);
    endtask

    typedef struct {
        logic [14:0] a;
        logic [15:0] d;
        logic        we;
        logic        chk;
        logic [15:0] exp;
    } vec_t;

    vec_t vt [14];

    initial begin
        int n;
        bit known, done;
        logic [15:0] e;
        logic [14:0] a;

        vt[0]  = '{15'h0005, 16'h1111, 1'b1, 1'b0, 16'h0000};
        vt[1]  = '{15'h0005, 16'h1234, 1'b1, 1'b1, 16'h1111}; // old value in write cycle
        vt[2]  = '{15'h0005, 16'h0000, 1'b0, 1'b1, 16'h1234};
        vt[3]  = '{15'h6002, 16'hDEAD, 1'b1, 1'b1, 16'h0000};
        vt[4]  = '{15'h6002, 16'h0000, 1'b0, 1'b1, 16'h0000};
        vt[5]  = '{15'h7FFF, 16'h0000, 1'b0, 1'b1, 16'h0000};
        vt[6]  = '{15'h4010, 16'hBEEF, 1'b1, 1'b0, 16'h0000};
        vt[7]  = '{15'h0010, 16'h7777, 1'b1, 1'b0, 16'h0000};
        vt[8]  = '{15'h4010, 16'h0000, 1'b0, 1'b1, 16'hBEEF};
        vt[9]  = '{15'h0010, 16'h0000, 1'b0, 1'b1, 16'h7777};
        vt[10] = '{15'h3FFF, 16'hA5A5, 1'b1, 1'b0, 16'h0000};
        vt[11] = '{15'h3FFF, 16'h0000, 1'b0, 1'b1, 16'hA5A5};
        vt[12] = '{15'h6000, 16'h0055, 1'b1, 1'b1, 16'h0000};
        vt[13] = '{15'h6000, 16'h0000, 1'b0, 1'b1, 16'h0000};

        // Reset state
        reset = 1'b1;
        rd(15'h6000);
        reset = 1'b0;
        rd(15'h6000);
        chk("reset_kbd", s_dout, 16'h0000);
        chk("reset_vvalid", {15'b0, s_vv}, 16'h0000);
        chk("reset_vdata", s_vd, 16'h0000);

        // CPU port vectors
        for (int i = 0; i < 14; i++) begin
            step(vt[i].a, vt[i].d, vt[i].we, 1'b0, 13'h0, 1'b0, 8'h0, 1'b0);
            if (vt[i].chk) chk($sformatf("vec%0d", i), s_dout, vt[i].exp);
        end

        // Video port
        step(15'h6002, 16'h0, 1'b0, 1'b1, 13'h0010, 1'b0, 8'h0, 1'b0);
        rd(15'h6002);
        chk("vid_valid_1", {15'b0, s_vv}, 16'h0001);
        chk("vid_data_1", s_vd, 16'hBEEF);
        rd(15'h6002);
        chk("vid_valid_idle", {15'b0, s_vv}, 16'h0000);
        chk("vid_data_hold", s_vd, 16'hBEEF);
        step(15'h4010, 16'h2222, 1'b1, 1'b1, 13'h0010, 1'b0, 8'h0, 1'b0);
        rd(15'h4010);
        chk("vid_same_cycle_old", s_vd, 16'hBEEF);
        chk("vid_same_cycle_valid", {15'b0, s_vv}, 16'h0001);
        chk("cpu_after_vid_wr", s_dout, 16'h2222);

        // Keyboard press/release
        key(8'h41, 1'b0); rd(15'h6000); chk("kbd_press41", s_dout, 16'h0041);
        key(8'h42, 1'b0); rd(15'h6000); chk("kbd_press42", s_dout, 16'h0042);
        key(8'h41, 1'b1); rd(15'h6000); chk("kbd_rel41", s_dout, 16'h0042);
        key(8'h00, 1'b0); rd(15'h6000); chk("kbd_press0", s_dout, 16'h0042);
        key(8'h42, 1'b1); rd(15'h6000); chk("kbd_rel42", s_dout, 16'h0000);

        // Hold timeout: visible for exactly H cycles
        key(8'h20, 1'b0);
        n = 0;
        for (int k = 0; k < H + 5; k++) begin
            rd(15'h6000);
            if (s_dout == 16'h0020) n++;
            else break;
        end
        chk("kbd_hold_cycles", 16'(n), 16'(H));
        chk("kbd_hold_expired", s_dout, 16'h0000);

        // Reset mid-hold
        key(8'h20, 1'b0);
        rd(15'h6000); rd(15'h6000);
        reset = 1'b1;
        rd(15'h6000);
        chk("kbd_before_reset", s_dout, 16'h0020);
        reset = 1'b0;
        rd(15'h6000);
        chk("kbd_after_reset", s_dout, 16'h0000);

        // Randomized run against the model
        for (int i = 0; i < 64; i++) wr(15'(i), 16'($urandom));
        for (int i = 0; i < 64; i++) wr(15'h4000 + 15'(i), 16'($urandom));
        for (int t = 0; t < 2000; t++) begin
            logic [15:0] d;
            logic [7:0]  kc;
            logic        ks;
            case ($urandom_range(0, 5))
                0, 1:    a = 15'($urandom_range(0, 63));
                2, 3:    a = 15'h4000 + 15'($urandom_range(0, 63));
                4:       a = 15'h6000;
                default: a = 15'($urandom_range(32'h6001, 32'h7FFF));
            endcase
            d = 16'($urandom);
            if (a == 15'h6001) d[0] = 1'b0;
            ks = ($urandom_range(0, 7) == 0);
            case ($urandom_range(0, 3))
                0: kc = 8'h00;
                1: kc = 8'h41;
                2: kc = 8'h42;
                default: kc = 8'h43;
            endcase
            e = model_read(a, known);
            begin
                logic        ev;
                logic [15:0] evd;
                bit          evk;
                ev = m_vvalid; evd = m_vdata; evk = m_vknown;
                step(a, d, 1'($urandom), 1'($urandom), 13'($urandom_range(0, 63)),
                     ks, kc, 1'($urandom));
                if (known) chk($sformatf("rand_dout@%h", a), s_dout, e);
                chk("rand_vvalid", {15'b0, s_vv}, {15'b0, ev});
                if (evk) chk("rand_vdata", s_vd, evd);
            end
        end

`ifdef SCREEN_CLEAR_EN
        // Full clear with one stalled cycle
        wr(15'h4000, 16'hFFFF);
        wr(15'h5FFF, 16'hFFFF);
        wr(15'h6001, 16'h0001);
        n = 0; done = 1'b0;
        for (int k = 0; k < 9000; k++) begin
            if (k == 2) begin
                wr(15'h4005, 16'h1234);
                n++;
            end else begin
                rd(15'h6001);
                if (s_dout == 16'h0001) n++;
                else begin done = 1'b1; break; end
            end
        end
        chk("clr_finished", {15'b0, done}, 16'h0001);
        chk("clr_busy_cycles", 16'(n), 16'd8193);
        rd(15'h4000); chk("clr_first", s_dout, 16'h0000);
        rd(15'h5FFF); chk("clr_last", s_dout, 16'h0000);
        rd(15'h4005); chk("clr_stalled_word", s_dout, 16'h0000);

        // Abort by reset after 100 clear cycles
        wr(15'h4063, 16'hFFFF);
        wr(15'h4064, 16'hFFFF);
        wr(15'h5FFF, 16'hFFFF);
        wr(15'h6001, 16'h0001);
        rd(15'h6001);
        chk("clr2_busy", s_dout, 16'h0001);
        for (int k = 1; k < 100; k++) rd(15'h6002);
        reset = 1'b1;
        rd(15'h6002);
        reset = 1'b0;
        rd(15'h6001); chk("clr2_abort_busy", s_dout, 16'h0000);
        rd(15'h4063); chk("clr2_word99", s_dout, 16'h0000);
        rd(15'h4064); chk("clr2_word100", s_dout, 16'hFFFF);
        rd(15'h5FFF); chk("clr2_last", s_dout, 16'hFFFF);
`else
        // CTRL is unmapped: no clear starts, reads are zero
        wr(15'h4000, 16'hFFFF);
        wr(15'h6001, 16'h0001);
        rd(15'h6001); chk("ctrl_unmapped", s_dout, 16'h0000);
        rd(15'h6002);
        rd(15'h4000); chk("no_clear", s_dout, 16'hFFFF);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
